// File: rtl/maze_pkg.sv
// Shared maze constants and state encoding for the move calculator, position tracker and display.
package maze_pkg;

    localparam int unsigned COLS       = 18;
    localparam int unsigned CELLS      = 198;
    localparam int unsigned START_CELL = 181;
    localparam int unsigned WALL_CODE  = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CRASH = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Linear cell index of a (row, col) grid position.
    function automatic logic [7:0] cell_index(input int unsigned row, input int unsigned col);
        return 8'(row * COLS + col);
    endfunction

endpackage

// File: rtl/maze_position_tracker_if.sv
// Move-calculator / game-state bus. time_left exists only when TIMEOUT_EN is defined.
interface maze_position_tracker_if;
    import maze_pkg::*;

    logic [7:0] next_count;
    logic [7:0] begin_spot;
    logic [7:0] end_spot;
    logic       CTRLbtn;
    logic [7:0] count;
    logic       game_run;
    state_t     state;
    logic [1:0] lives;
    logic [9:0] moves;
    logic       win;
    logic       over;
`ifdef TIMEOUT_EN
    logic [9:0] time_left;
`endif

    modport master (
        output next_count, begin_spot, end_spot, CTRLbtn,
        input  count, game_run, state, lives, moves, win, over
`ifdef TIMEOUT_EN
        , time_left
`endif
    );

    modport slave (
        input  next_count, begin_spot, end_spot, CTRLbtn,
        output count, game_run, state, lives, moves, win, over
`ifdef TIMEOUT_EN
        , time_left
`endif
    );

endinterface

// File: rtl/rise_pulse.sv
// Registered rising-edge detector: pulse_c is high for the tick where d goes 0 -> 1.
module rise_pulse (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic pulse_c
);

    logic d_q;

    always_ff @(posedge CLK) begin
        if (!RESET) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign pulse_c = d & ~d_q;

endmodule

// File: rtl/maze_position_tracker.sv
// Maze game-state stage: player cell, crash/goal detection, lives and move count.
// Optional play timer enabled with TIMEOUT_EN (adds time_left output).
module maze_position_tracker
    import maze_pkg::*;
#(
    parameter int unsigned MAX_LIVES = 3,
    parameter int unsigned MOVE_MAX  = 999
`ifdef TIMEOUT_EN
    , parameter int unsigned TIME_LIMIT = 600
`endif
) (
    input logic                    CLK,
    input logic                    RESET,
    maze_position_tracker_if.slave bus
);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [1:0] lives_q, lives_d;
    logic [9:0] moves_q, moves_d;
    logic       game_run_q, win_q, over_q;
    logic       start_c, crash_c;
    logic [9:0] moves_inc_c;

    rise_pulse u_ctrl_edge (
        .CLK    (CLK),
        .RESET  (RESET),
        .d      (bus.CTRLbtn),
        .pulse_c(start_c)
    );

    assign crash_c     = (bus.next_count == 8'(WALL_CODE)) || (bus.next_count >= 8'(CELLS));
    assign moves_inc_c = (moves_q == 10'(MOVE_MAX)) ? moves_q : moves_q + 10'd1;

`ifdef TIMEOUT_EN
    logic [9:0] time_left_q, time_left_d;
`endif

    // Next-state and next-value logic for the game FSM and its counters
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lives_d = lives_q;
        moves_d = moves_q;
`ifdef TIMEOUT_EN
        time_left_d = time_left_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = PLAY;
                    count_d = bus.begin_spot;
                    moves_d = 10'd0;
`ifdef TIMEOUT_EN
                    time_left_d = 10'(TIME_LIMIT);
`endif
                end
            end
            PLAY: begin
`ifdef TIMEOUT_EN
                time_left_d = (time_left_q != 10'd0) ? time_left_q - 10'd1 : 10'd0;
`endif
                if (crash_c) begin
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    state_d = (lives_q <= 2'd1) ? OVER : CRASH;
                end
`ifdef TIMEOUT_EN
                else if (time_left_q <= 10'd1) begin
                    state_d = OVER;
                end
`endif
                else if (bus.next_count == bus.end_spot) begin
                    count_d = bus.end_spot;
                    moves_d = moves_inc_c;
                    state_d = WIN;
                end else if (bus.next_count != count_q) begin
                    count_d = bus.next_count;
                    moves_d = moves_inc_c;
                end
            end
            CRASH: begin
                if (bus.next_count != 8'(WALL_CODE)) begin
                    state_d = PLAY;
                    count_d = bus.next_count;
                end
            end
            WIN: begin
                if (start_c) begin
                    state_d = IDLE;
                    lives_d = 2'(MAX_LIVES);
                end
            end
            OVER: begin
                if (start_c) begin
                    state_d = IDLE;
                    lives_d = 2'(MAX_LIVES);
                    moves_d = 10'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers; status flags are decoded from the next state so they align with it
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= IDLE;
            count_q    <= 8'(START_CELL);
            lives_q    <= 2'(MAX_LIVES);
            moves_q    <= 10'd0;
            game_run_q <= 1'b0;
            win_q      <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lives_q    <= lives_d;
            moves_q    <= moves_d;
            game_run_q <= (state_d == PLAY) || (state_d == CRASH);
            win_q      <= (state_d == WIN);
            over_q     <= (state_d == OVER);
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RESET) time_left_q <= 10'(TIME_LIMIT);
        else        time_left_q <= time_left_d;
    end

    assign bus.time_left = time_left_q;
`endif

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.lives    = lives_q;
    assign bus.moves    = moves_q;
    assign bus.game_run = game_run_q;
    assign bus.win      = win_q;
    assign bus.over     = over_q;

endmodule

// File: tb/tb_maze_position_tracker.sv
// Directed self-checking bench for maze_position_tracker.
module tb_maze_position_tracker;
    import maze_pkg::*;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    maze_position_tracker_if bus ();

`ifdef TIMEOUT_EN
    maze_position_tracker #(.TIME_LIMIT(40)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );
`else
    maze_position_tracker dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_core(input string tag, input int st, input int cnt,
                              input int lv, input int mv, input int run);
        check({tag, ".state"},    int'(bus.state),    st);
        check({tag, ".count"},    int'(bus.count),    cnt);
        check({tag, ".lives"},    int'(bus.lives),    lv);
        check({tag, ".moves"},    int'(bus.moves),    mv);
        check({tag, ".game_run"}, int'(bus.game_run), run);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET = 1'b0;
        bus.CTRLbtn    = 1'b0;
        bus.next_count = 8'd0;
        bus.begin_spot = 8'd19;
        bus.end_spot   = 8'd40;
        tick();
        check_core("reset", 0, 181, 3, 0, 0);
        check("reset.win",  int'(bus.win),  0);
        check("reset.over", int'(bus.over), 0);

        RESET = 1'b1;
        tick();
        check("idle_hold.state", int'(bus.state), 0);

        // Start from IDLE, then CTRL held high must not restart
        bus.CTRLbtn = 1'b1;
        bus.next_count = 8'd19;
        tick();
        check_core("start", 1, 19, 3, 0, 1);
        tick();
        tick();
        check_core("ctrl_held", 1, 19, 3, 0, 1);
        bus.CTRLbtn = 1'b0;

        bus.next_count = 8'd20;  tick();
        check_core("move1", 1, 20, 3, 1, 1);
        bus.next_count = 8'd38;  tick();
        check_core("move2", 1, 38, 3, 2, 1);
        tick();
        check_core("move_same", 1, 38, 3, 2, 1);

        bus.next_count = 8'd255; tick();
        check_core("crash1", 2, 38, 2, 2, 1);
        bus.CTRLbtn = 1'b1;      tick();
        check_core("crash_hold", 2, 38, 2, 2, 1);
        bus.CTRLbtn = 1'b0;
        bus.next_count = 8'd19;  tick();
        check_core("crash_exit", 1, 19, 2, 2, 1);
        bus.next_count = 8'd200; tick();
        check_core("crash2_oob", 2, 19, 1, 2, 1);
        bus.next_count = 8'd19;  tick();
        check_core("crash2_exit", 1, 19, 1, 2, 1);
        bus.next_count = 8'd20;  tick();
        check_core("move3", 1, 20, 1, 3, 1);
        bus.next_count = 8'd255; tick();
        check_core("over", 4, 20, 0, 3, 0);
        check("over.over", int'(bus.over), 1);
        bus.next_count = 8'd21;  tick();
        check_core("over_frozen", 4, 20, 0, 3, 0);
        bus.CTRLbtn = 1'b1;      tick();
        check_core("over_to_idle", 0, 20, 3, 0, 0);
        check("over_to_idle.over", int'(bus.over), 0);
        bus.CTRLbtn = 1'b0;      tick();

        // Second game: one crash, then reach the goal
        bus.CTRLbtn = 1'b1;      tick();
        check_core("start2", 1, 19, 3, 0, 1);
        bus.CTRLbtn = 1'b0;
        bus.next_count = 8'd255; tick();
        check_core("g2_crash", 2, 19, 2, 0, 1);
        bus.next_count = 8'd19;  tick();
        check_core("g2_resume", 1, 19, 2, 0, 1);
        bus.next_count = 8'd40;  tick();
        check_core("win", 3, 40, 2, 1, 0);
        check("win.win", int'(bus.win), 1);
        bus.next_count = 8'd21;  tick();
        check_core("win_frozen", 3, 40, 2, 1, 0);
        bus.CTRLbtn = 1'b1;      tick();
        check_core("win_to_idle", 0, 40, 3, 1, 0);
        check("win_to_idle.win", int'(bus.win), 0);
        bus.CTRLbtn = 1'b0;      tick();

        // Cell-range boundary: 197 valid, 198 crashes
        bus.CTRLbtn = 1'b1;      tick();
        check_core("start3", 1, 19, 3, 0, 1);
        bus.CTRLbtn = 1'b0;
        bus.next_count = 8'd197; tick();
        check_core("cell197", 1, 197, 3, 1, 1);
        bus.next_count = 8'd198; tick();
        check_core("cell198", 2, 197, 2, 1, 1);

        RESET = 1'b0;            tick();
        check_core("reset_mid", 0, 181, 3, 0, 0);
        RESET = 1'b1;

`ifndef TIMEOUT_EN
        // Move counter saturation
        bus.CTRLbtn = 1'b1;      tick();
        bus.CTRLbtn = 1'b0;
        for (int i = 0; i < 1010; i++) begin
            bus.next_count = (i % 2 == 0) ? 8'd20 : 8'd19;
            tick();
        end
        check_core("moves_sat", 1, 19, 3, 999, 1);
`else
        // Timeout after TIME_LIMIT play ticks
        bus.next_count = 8'd19;
        bus.CTRLbtn = 1'b1;      tick();
        check("to_start.time_left", int'(bus.time_left), 40);
        bus.CTRLbtn = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        check_core("to_last", 1, 19, 3, 0, 1);
        check("to_last.time_left", int'(bus.time_left), 1);
        tick();
        check_core("timeout", 4, 19, 3, 0, 0);
        check("timeout.time_left", int'(bus.time_left), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
